// File: rtl/dram_cache_pkg.sv
// Shared DRAM-cache constants and the eviction write-back FSM state encoding.
package dram_cache_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 16;
  localparam int TID_W  = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_RESP = 2'd2
  } state_e;
endpackage

// File: rtl/evict_aw_w.sv
// Eviction write-back engine: pops one {tid, addr} entry and one line, issues a
// single-beat AXI write on AW/W, then pulses a tid-tagged completion.
//
// state  | meaning
// S_IDLE | waiting for both eviction FIFOs to be non-empty
// S_RUN  | AW and/or W still waiting for their handshake
// S_RESP | completion valid, waiting for bready_i
module evict_aw_w
  import dram_cache_pkg::*;
#(
  parameter int ADDR_W_P = ADDR_W,
  parameter int DATA_W_P = DATA_W,
  parameter int ID_W_P   = ID_W,
  parameter int TID_W_P  = TID_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic [ID_W_P-1:0]           awid_o,
  output logic [ADDR_W_P-1:0]         awaddr_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [ID_W_P-1:0]           wid_o,
  output logic [DATA_W_P-1:0]         wdata_o,
  output logic                        wvalid_o,
  input  logic                        wready_i,
  output logic [ID_W_P-1:0]           bid_o,
  output logic                        bvalid_o,
  input  logic                        bready_i,
  input  logic                        awfifo_aempty_i,
  output logic                        awfifo_rden_o,
  input  logic [TID_W_P+ADDR_W_P-1:0] awfifo_data_i,
  input  logic                        wfifo_aempty_i,
  output logic                        wfifo_rden_o,
  input  logic [DATA_W_P-1:0]         wfifo_data_i
);

  localparam int PAD_W = ID_W_P - TID_W_P;

  state_e                state_q, state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bvalid_q, bvalid_d;
  logic [ADDR_W_P-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W_P-1:0]   wdata_q, wdata_d;
  logic [TID_W_P-1:0]    tid_q, tid_d;
  logic [TID_W_P-1:0]    btid_q, btid_d;
  logic                  pop;

  // Both FIFOs are always popped together, and only from idle.
  assign pop           = (state_q == S_IDLE) && !awfifo_aempty_i && !wfifo_aempty_i;
  assign awfifo_rden_o = pop;
  assign wfifo_rden_o  = pop;

  always_comb begin
    state_d   = state_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bvalid_d  = bvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    tid_d     = tid_q;
    btid_d    = btid_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          awaddr_d  = awfifo_data_i[ADDR_W_P-1:0];
          tid_d     = awfifo_data_i[TID_W_P+ADDR_W_P-1:ADDR_W_P];
          wdata_d   = wfifo_data_i;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        // A dropped valid doubles as that channel's done flag.
        if (awvalid_q && awready_i) awvalid_d = 1'b0;
        if (wvalid_q && wready_i)   wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          bvalid_d = 1'b1;
          btid_d   = tid_q;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid_q && bready_i) begin
          bvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bvalid_d  = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      tid_q     <= '0;
      btid_q    <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bvalid_q  <= bvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      tid_q     <= tid_d;
      btid_q    <= btid_d;
    end
  end

  assign awvalid_o = awvalid_q;
  assign wvalid_o  = wvalid_q;
  assign bvalid_o  = bvalid_q;
  assign awaddr_o  = awaddr_q;
  assign wdata_o   = wdata_q;
  assign awid_o    = {{PAD_W{1'b0}}, tid_q};
  assign wid_o     = {{PAD_W{1'b0}}, tid_q};
  assign bid_o     = {{PAD_W{1'b0}}, btid_q};

endmodule

// File: tb/tb_evict_aw_w.sv
// Directed bench for evict_aw_w: reset, single eviction, AW backpressure,
// one-FIFO-only hold-off, completion stall and reset during S_RUN.
module tb_evict_aw_w;
  import dram_cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [ID_W-1:0]   awid_o, wid_o, bid_o;
  logic [ADDR_W-1:0] awaddr_o;
  logic              awvalid_o, awready_i;
  logic [DATA_W-1:0] wdata_o;
  logic              wvalid_o, wready_i;
  logic              bvalid_o, bready_i;
  logic              awfifo_aempty_i, awfifo_rden_o;
  logic [TID_W+ADDR_W-1:0] awfifo_data_i;
  logic              wfifo_aempty_i, wfifo_rden_o;
  logic [DATA_W-1:0] wfifo_data_i;

  int checks = 0;
  int errors = 0;

  evict_aw_w dut (
    .clk(clk), .rst_n(rst_n),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_o(bid_o), .bvalid_o(bvalid_o), .bready_i(bready_i),
    .awfifo_aempty_i(awfifo_aempty_i), .awfifo_rden_o(awfifo_rden_o),
    .awfifo_data_i(awfifo_data_i),
    .wfifo_aempty_i(wfifo_aempty_i), .wfifo_rden_o(wfifo_rden_o),
    .wfifo_data_i(wfifo_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic entry(input logic [TID_W-1:0] tid, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] data);
    awfifo_data_i = {tid, addr};
    wfifo_data_i  = data;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_awrden"}, DATA_W'(awfifo_rden_o), '0);
    chk({tag, "_wrden"},  DATA_W'(wfifo_rden_o),  '0);
    chk({tag, "_awvalid"}, DATA_W'(awvalid_o), '0);
    chk({tag, "_wvalid"},  DATA_W'(wvalid_o),  '0);
    chk({tag, "_bvalid"},  DATA_W'(bvalid_o),  '0);
  endtask

  initial begin
    rst_n = 1'b0;
    awready_i = 1'b1; wready_i = 1'b1; bready_i = 1'b1;
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    entry('0, '0, '0);
    #3;
    chk_quiet("reset");
    chk("reset_awaddr", DATA_W'(awaddr_o), '0);
    chk("reset_wdata", wdata_o, '0);
    chk("reset_bid", DATA_W'(bid_o), '0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_quiet("idle_empty");
    end

    // Single eviction with all readies high.
    entry(10'd1, 64'd1, 512'd12);
    awfifo_aempty_i = 1'b0; wfifo_aempty_i = 1'b0;
    #1;
    chk("single_awrden", DATA_W'(awfifo_rden_o), 1);
    chk("single_wrden", DATA_W'(wfifo_rden_o), 1);
    step();
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    #1;
    chk("single_rden_pulse", DATA_W'(awfifo_rden_o | wfifo_rden_o), 0);
    chk("single_awvalid", DATA_W'(awvalid_o), 1);
    chk("single_wvalid", DATA_W'(wvalid_o), 1);
    chk("single_awaddr", DATA_W'(awaddr_o), 1);
    chk("single_wdata", wdata_o, 12);
    chk("single_awid", DATA_W'(awid_o), 1);
    chk("single_wid", DATA_W'(wid_o), 1);
    chk("single_bvalid_early", DATA_W'(bvalid_o), 0);
    step();
    chk("single_awvalid_drop", DATA_W'(awvalid_o), 0);
    chk("single_wvalid_drop", DATA_W'(wvalid_o), 0);
    chk("single_bvalid", DATA_W'(bvalid_o), 1);
    chk("single_bid", DATA_W'(bid_o), 1);
    step();
    chk_quiet("single_idle");
    chk("single_awaddr_hold", DATA_W'(awaddr_o), 1);
    chk("single_wdata_hold", wdata_o, 12);

    // AW backpressure for three cycles, W accepted immediately.
    entry(10'd3, 64'h100, 512'h55);
    awfifo_aempty_i = 1'b0; wfifo_aempty_i = 1'b0;
    awready_i = 1'b0;
    step();
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    chk("bp_awvalid_c1", DATA_W'(awvalid_o), 1);
    chk("bp_wvalid_c1", DATA_W'(wvalid_o), 1);
    step();
    chk("bp_wvalid_drop", DATA_W'(wvalid_o), 0);
    chk("bp_awvalid_c2", DATA_W'(awvalid_o), 1);
    chk("bp_bvalid_c2", DATA_W'(bvalid_o), 0);
    step();
    chk("bp_awvalid_c3", DATA_W'(awvalid_o), 1);
    chk("bp_awaddr_stable", DATA_W'(awaddr_o), 64'h100);
    chk("bp_bvalid_c3", DATA_W'(bvalid_o), 0);
    awready_i = 1'b1;
    step();
    chk("bp_awvalid_drop", DATA_W'(awvalid_o), 0);
    chk("bp_bvalid", DATA_W'(bvalid_o), 1);
    chk("bp_bid", DATA_W'(bid_o), 3);
    step();
    chk_quiet("bp_idle");

    // Only the AW FIFO has data: nothing may pop.
    entry(10'd5, 64'h200, 512'h77);
    awfifo_aempty_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_quiet("one_fifo");
      step();
    end
    chk_quiet("one_fifo_end");

    // W FIFO fills; complete with bready low and both FIFOs still non-empty.
    wfifo_aempty_i = 1'b0;
    bready_i = 1'b0;
    #1;
    chk("both_rden", DATA_W'(awfifo_rden_o & wfifo_rden_o), 1);
    step();
    entry(10'd2, 64'd2, 512'h34);
    chk("both_awaddr", DATA_W'(awaddr_o), 64'h200);
    chk("both_wdata", wdata_o, 512'h77);
    step();
    chk("stall_bid", DATA_W'(bid_o), 5);
    for (int i = 0; i < 4; i++) begin
      chk("stall_bvalid", DATA_W'(bvalid_o), 1);
      chk("stall_no_rden", DATA_W'(awfifo_rden_o | wfifo_rden_o), 0);
      chk("stall_no_awvalid", DATA_W'(awvalid_o), 0);
      step();
    end
    bready_i = 1'b1;
    step();
    chk("stall_bvalid_clr", DATA_W'(bvalid_o), 0);
    chk("stall_next_rden", DATA_W'(awfifo_rden_o & wfifo_rden_o), 1);
    step();
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    chk("next_awaddr", DATA_W'(awaddr_o), 2);
    chk("next_wdata", wdata_o, 512'h34);
    chk("next_awid", DATA_W'(awid_o), 2);
    chk("next_awvalid", DATA_W'(awvalid_o), 1);
    step();
    chk("next_bid", DATA_W'(bid_o), 2);
    chk("next_bvalid", DATA_W'(bvalid_o), 1);
    step();
    chk_quiet("next_idle");

    // Reset while AW is stalled in S_RUN.
    entry(10'd7, 64'h300, 512'h99);
    awfifo_aempty_i = 1'b0; wfifo_aempty_i = 1'b0;
    awready_i = 1'b0; wready_i = 1'b0;
    step();
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    chk("mid_awvalid", DATA_W'(awvalid_o), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_awvalid", DATA_W'(awvalid_o), 0);
    chk("rst_wvalid", DATA_W'(wvalid_o), 0);
    chk("rst_awaddr", DATA_W'(awaddr_o), 0);
    chk("rst_wdata", wdata_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    awready_i = 1'b1; wready_i = 1'b1;
    step();
    chk_quiet("post_rst");
    awfifo_aempty_i = 1'b0; wfifo_aempty_i = 1'b0;
    #1;
    chk("post_rst_idle_pop", DATA_W'(awfifo_rden_o & wfifo_rden_o), 1);
    step();
    awfifo_aempty_i = 1'b1; wfifo_aempty_i = 1'b1;
    chk("post_rst_awaddr", DATA_W'(awaddr_o), 64'h300);
    chk("post_rst_awid", DATA_W'(awid_o), 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
